if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage ARM core.
- Upstream producer of the decode stage's PC_in/instruction inputs.
- Fetches from a variable-latency instruction memory using a req/ready handshake.
- Honours the hazard freeze from the hazard-detect module and the branch redirect/flush from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).
- BUBBLE_INSTR, 32'h0000_0000, instruction value driven while the IF/ID register holds a bubble.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  hazard stall; IF/ID register must hold its contents.
- branch_taken  input  1  execute-stage redirect; flushes IF/ID.
- branch_addr  input  32  redirect target; bits [1:0] ignored (forced 0).
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory completes the current request this cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (word aligned).
- PC_out  output  32  fetched PC+4, registered (IF/ID).
- instruction  output  32  fetched instruction, registered (IF/ID).
- valid  output  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Memory protocol:
  - imem_req asserted with imem_addr stable until the cycle imem_ready=1.
  - imem_addr must not change while a request is outstanding.
  - imem_ready with imem_req=0 is ignored.
- Internal state:
  - fetch_pc register.
  - 32-bit skid buffer plus its PC.
  - FSM {S_FETCH, S_HOLD, S_DISCARD}.
- Reset (async): fetch_pc=RESET_PC, state=S_FETCH, PC_out=0, instruction=BUBBLE_INSTR, valid=0, skid cleared.
  - imem_req is 0 while rst=1 and 1 in the first cycle after release.
- S_FETCH: imem_req=1, imem_addr=fetch_pc.
  - imem_ready & ~freeze: IF/ID <= {fetch_pc+4, imem_rdata, valid=1}; fetch_pc += 4; stay. Back-to-back single-cycle memory gives one instruction per cycle.
  - imem_ready & freeze: skid <= imem_rdata with its PC; fetch_pc += 4; go to S_HOLD. IF/ID holds.
  - ~imem_ready & ~freeze: IF/ID <= bubble (valid=0, instruction=BUBBLE_INSTR, PC_out unchanged).
  - ~imem_ready & freeze: IF/ID holds.
- S_HOLD: imem_req=0.
  - ~freeze: IF/ID <= skid contents with valid=1; go to S_FETCH.
  - freeze: hold.
- S_DISCARD: imem_req=1, imem_addr = the old outstanding address.
  - Wait for imem_ready; drop the returned data.
  - Then go to S_FETCH, which fetches the already-updated fetch_pc.
  - IF/ID shows a bubble unless freeze=1.
- branch_taken has priority over everything, including freeze:
  - fetch_pc <= {branch_addr[31:2],2'b00}.
  - IF/ID <= bubble.
  - Skid invalidated.
- Branch next-state rules:
  - In S_FETCH with request outstanding (imem_ready=0): go to S_DISCARD.
  - In S_FETCH with imem_ready=1 in the same cycle: data dropped, go to S_FETCH; target fetched next cycle.
  - In S_HOLD: go to S_FETCH.
  - In S_DISCARD: stay in S_DISCARD (target updated) until ready.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Outputs are registered only. imem_req and imem_addr are decoded from state/fetch_pc, with no combinational path from inputs.

Test Plan:
- Reset/stream:
  - Stimulus: rst pulse with imem_ready tied 1, imem_rdata = addr-derived words.
  - Required: imem_addr 0, 4, 8, …; instruction follows one cycle later; PC_out = 4, 8, 12; valid=1 continuously.
- Wait states:
  - Stimulus: imem_ready low for 3 cycles on addr 8.
  - Required: imem_addr held at 8 and imem_req=1 for all 4 cycles; IF/ID valid=0 for 3 cycles, then instruction@8 with PC_out=12.
- Freeze with skid:
  - Stimulus: freeze=1 for 2 cycles starting when instr@4 returns.
  - Required: IF/ID keeps instr@0; imem_req=0 during S_HOLD; after release instr@4 appears with PC_out=8; no instruction lost or duplicated.
- Branch during outstanding fetch:
  - Stimulus: branch_taken=1 with branch_addr=32'h0000_0103 while addr 16 is pending; ready 2 cycles later.
  - Required: addr stays 16 until ready; that data is discarded; next imem_addr=32'h100; valid=0 until instr@0x100 arrives.
- Branch + freeze + ready in the same cycle:
  - Required: IF/ID becomes a bubble, fetched data is dropped, next request is to the target.
- Wrap/async reset:
  - Stimulus: RESET_PC=32'hFFFF_FFFC; then assert rst mid-S_DISCARD.
  - Required: second fetch addr is 0; on rst, imem_req drops immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and the memory.
// master = fetch stage (issues requests), slave = memory (completes them).
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a variable-latency req/ready bus, parks a word that returns
// during a freeze in a one-entry skid buffer, and discards the in-flight
// word when a branch redirects the fetch stream.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_addr,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             PC_out,
  output logic [31:0]             instruction,
  output logic                    valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] disc_addr_q, disc_addr_d;   // address still owed by memory after a redirect
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        run_q;                      // low only until the first edge after reset

  logic        req_int;
  logic        accept;
  logic [31:0] pc_plus4;

  // Low address bits of a branch target carry no meaning for word fetches.
  logic unused_baddr_bits;
  assign unused_baddr_bits = ^branch_addr[1:0];

  // Request/address decode purely from registered state.
  assign req_int        = run_q && (state_q != S_HOLD);
  assign accept         = req_int && imem.imem_ready;
  assign pc_plus4       = fetch_pc_q + 32'd4;
  assign imem.imem_req  = req_int;
  assign imem.imem_addr = (state_q == S_DISCARD) ? disc_addr_q : fetch_pc_q;

  assign PC_out      = pc_out_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

  // State register, fetch PC, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      disc_addr_q  <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      pc_out_q     <= 32'h0;
      instr_q      <= BUBBLE_INSTR;
      valid_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      disc_addr_q  <= disc_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      run_q        <= 1'b1;
    end
  end

  // Next-state and IF/ID update; a branch overrides freeze and everything else.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    disc_addr_d  = disc_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    pc_out_d     = pc_out_q;
    instr_d      = instr_q;
    valid_d      = valid_q;

    if (branch_taken) begin
      fetch_pc_d   = {branch_addr[31:2], 2'b00};
      instr_d      = BUBBLE_INSTR;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          // An unfinished request must still be completed, then thrown away.
          if (req_int && !imem.imem_ready) begin
            state_d     = S_DISCARD;
            disc_addr_d = fetch_pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (accept) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept) begin
            fetch_pc_d = pc_plus4;
            if (freeze) begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pc_plus4;
              skid_valid_d = 1'b1;
              state_d      = S_HOLD;
            end else begin
              pc_out_d = pc_plus4;
              instr_d  = imem.imem_rdata;
              valid_d  = 1'b1;
            end
          end else if (!freeze) begin
            instr_d = BUBBLE_INSTR;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            pc_out_d     = skid_pc_q;
            instr_d      = skid_instr_q;
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (accept) state_d = S_FETCH;
          if (!freeze) begin
            instr_d = BUBBLE_INSTR;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: scoreboard of expected IF/ID
// contents pushed when a fetch completes, popped when it should appear.
module tb_if_fetch_stage;

  localparam logic [31:0] BUBBLE = 32'hE1A0_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] pc_out, instr;
  logic        valid;

  logic        rst2 = 1'b1;
  logic        freeze2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [31:0] baddr2 = 32'h0;
  logic [31:0] pc_out2, instr2;
  logic        valid2;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t held;

  if_fetch_stage_if bus ();
  if_fetch_stage_if bus2 ();

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hE1A0_5A5A;
  endfunction

  assign bus.imem_rdata  = word(bus.imem_addr);
  assign bus2.imem_rdata = word(bus2.imem_addr);

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem(bus),
    .PC_out(pc_out), .instruction(instr), .valid(valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BUBBLE_INSTR(BUBBLE)) dut2 (
    .clk(clk), .rst(rst2), .freeze(freeze2), .branch_taken(branch2),
    .branch_addr(baddr2), .imem(bus2),
    .PC_out(pc_out2), .instruction(instr2), .valid(valid2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; bus.imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.imem_req, valid, pc_out, instr} !== {1'b0, 1'b0, 32'h0, BUBBLE}) begin
      failures++;
      $display("FAIL reset_state req=%0b valid=%0b pc=%h instr=%h exp 0 0 0 %h",
               bus.imem_req, valid, pc_out, instr, BUBBLE);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(4 * k)}) begin
        failures++;
        $display("FAIL stream_addr req=%0b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'(4 * k));
      end
      sb.push_back('{pc: 32'(4 * k + 4), ins: word(32'(4 * k))});
      tick();
      held = sb.pop_front();
      $display("txn stream pc=%h instr=%h valid=%0b", pc_out, instr, valid);
      checks++;
      if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
        failures++;
        $display("FAIL stream_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
      end
    end
  endtask

  task automatic test_wait_states();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd8}) begin
        failures++;
        $display("FAIL wait_addr req=%0b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr);
      end
      tick();
      $display("txn wait cycle=%0d valid=%0b instr=%h", i, valid, instr);
      checks++;
      if ({valid, pc_out, instr} !== {1'b0, 32'd8, BUBBLE}) begin
        failures++;
        $display("FAIL wait_bubble valid=%0b pc=%h instr=%h exp 0 8 %h", valid, pc_out, instr, BUBBLE);
      end
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd8}) begin
      failures++;
      $display("FAIL wait_addr4 req=%0b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ready = 1'b1;
    sb.push_back('{pc: 32'd12, ins: word(32'd8)});
    tick();
    held = sb.pop_front();
    $display("txn wait_done pc=%h instr=%h", pc_out, instr);
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL wait_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
    end
  endtask

  task automatic test_freeze_skid();
    apply_reset();
    bus.imem_ready = 1'b1;
    sb.push_back('{pc: 32'd4, ins: word(32'd0)});
    tick();
    held = sb.pop_front();
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL frz_first valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd4}) begin
      failures++;
      $display("FAIL frz_addr req=%0b addr=%h exp req=1 addr=4", bus.imem_req, bus.imem_addr);
    end
    freeze = 1'b1;
    sb.push_back('{pc: 32'd8, ins: word(32'd4)});
    for (int i = 0; i < 2; i++) begin
      tick();
      $display("txn freeze cycle=%0d req=%0b pc=%h instr=%h", i, bus.imem_req, pc_out, instr);
      checks++;
      if ({bus.imem_req, valid, pc_out, instr} !== {1'b0, 1'b1, held.pc, held.ins}) begin
        failures++;
        $display("FAIL frz_hold req=%0b valid=%0b pc=%h instr=%h exp 0 1 %h %h",
                 bus.imem_req, valid, pc_out, instr, held.pc, held.ins);
      end
    end
    freeze = 1'b0;
    tick();
    held = sb.pop_front();
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL frz_skid_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd8}) begin
      failures++;
      $display("FAIL frz_resume req=%0b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr);
    end
    sb.push_back('{pc: 32'd12, ins: word(32'd8)});
    tick();
    held = sb.pop_front();
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins} || sb.size() != 0) begin
      failures++;
      $display("FAIL frz_next valid=%0b pc=%h instr=%h q=%0d exp 1 %h %h q=0",
               valid, pc_out, instr, sb.size(), held.pc, held.ins);
    end
  endtask

  task automatic test_branch_pending();
    apply_reset();
    bus.imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{pc: 32'(4 * k + 4), ins: word(32'(4 * k))});
      tick();
      held = sb.pop_front();
      checks++;
      if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
        failures++;
        $display("FAIL br_pre valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
      end
    end
    bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_0103;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd16}) begin
        failures++;
        $display("FAIL br_old_addr cycle=%0d req=%0b addr=%h exp req=1 addr=10", i, bus.imem_req, bus.imem_addr);
      end
      if (i == 2) bus.imem_ready = 1'b1;
      tick();
      branch_taken = 1'b0;
      $display("txn branch cycle=%0d valid=%0b instr=%h", i, valid, instr);
      checks++;
      if ({valid, instr} !== {1'b0, BUBBLE}) begin
        failures++;
        $display("FAIL br_bubble cycle=%0d valid=%0b instr=%h exp 0 %h", i, valid, instr, BUBBLE);
      end
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL br_target req=%0b addr=%h exp req=1 addr=100", bus.imem_req, bus.imem_addr);
    end
    sb.push_back('{pc: 32'h104, ins: word(32'h100)});
    tick();
    held = sb.pop_front();
    $display("txn branch_target pc=%h instr=%h", pc_out, instr);
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL br_target_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
    end
  endtask

  task automatic test_branch_freeze_ready();
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0200; bus.imem_ready = 1'b1;
    tick();
    freeze = 1'b0; branch_taken = 1'b0;
    checks++;
    if ({valid, pc_out, instr} !== {1'b0, 32'h104, BUBBLE}) begin
      failures++;
      $display("FAIL bfr_bubble valid=%0b pc=%h instr=%h exp 0 104 %h", valid, pc_out, instr, BUBBLE);
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL bfr_target req=%0b addr=%h exp req=1 addr=200", bus.imem_req, bus.imem_addr);
    end
    sb.push_back('{pc: 32'h204, ins: word(32'h200)});
    tick();
    held = sb.pop_front();
    $display("txn bfr_target pc=%h instr=%h", pc_out, instr);
    checks++;
    if ({valid, pc_out, instr} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL bfr_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid, pc_out, instr, held.pc, held.ins);
    end
  endtask

  task automatic test_wrap_async_reset();
    @(negedge clk);
    rst2 = 1'b1; bus2.imem_ready = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    tick();
    checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_first req=%0b addr=%h exp req=1 addr=fffffffc", bus2.imem_req, bus2.imem_addr);
    end
    sb.push_back('{pc: 32'h0, ins: word(32'hFFFF_FFFC)});
    tick();
    held = sb.pop_front();
    $display("txn wrap pc=%h instr=%h", pc_out2, instr2);
    checks++;
    if ({valid2, pc_out2, instr2} !== {1'b1, held.pc, held.ins}) begin
      failures++;
      $display("FAIL wrap_out valid=%0b pc=%h instr=%h exp 1 %h %h", valid2, pc_out2, instr2, held.pc, held.ins);
    end
    checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_second req=%0b addr=%h exp req=1 addr=0", bus2.imem_req, bus2.imem_addr);
    end
    bus2.imem_ready = 1'b0; branch2 = 1'b1; baddr2 = 32'h40;
    tick();
    branch2 = 1'b0;
    checks++;
    if ({bus2.imem_req, bus2.imem_addr, valid2} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL wrap_discard req=%0b addr=%h valid=%0b exp 1 0 0", bus2.imem_req, bus2.imem_addr, valid2);
    end
    @(negedge clk);
    #2;
    rst2 = 1'b1;
    #1;
    checks++;
    if ({bus2.imem_req, bus2.imem_addr, valid2, pc_out2, instr2} !==
        {1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, BUBBLE}) begin
      failures++;
      $display("FAIL async_rst req=%0b addr=%h valid=%0b pc=%h instr=%h exp 0 fffffffc 0 0 %h",
               bus2.imem_req, bus2.imem_addr, valid2, pc_out2, instr2, BUBBLE);
    end
    @(negedge clk);
    rst2 = 1'b0; bus2.imem_ready = 1'b1;
    tick();
    checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL rst_restart req=%0b addr=%h exp req=1 addr=fffffffc", bus2.imem_req, bus2.imem_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ready  = 1'b0;
    bus2.imem_ready = 1'b0;
    test_reset();
    test_wait_states();
    test_freeze_skid();
    test_branch_pending();
    test_branch_freeze_ready();
    test_wrap_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
